// File: rtl/sump_cmd_pkg.sv
// Shared opcodes, trigger sub-op codes and arm/capture FSM encoding for the SUMP command decoder.
package sump_cmd_pkg;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_XON       = 8'h11;
  localparam logic [7:0] OP_XOFF      = 8'h13;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_COUNT     = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;
  localparam logic [7:0] OP_TRIG_BASE = 8'hC0;

  localparam logic [1:0] TRIG_SUB_MASK  = 2'b00;
  localparam logic [1:0] TRIG_SUB_VALUE = 2'b01;
  localparam logic [1:0] TRIG_SUB_CFG   = 2'b10;
  localparam logic [1:0] TRIG_SUB_NONE  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // 0xC0..0xCF: upper nibble selects the trigger-write family.
  function automatic logic is_trig_op(input logic [7:0] op);
    return op[7:4] == OP_TRIG_BASE[7:4];
  endfunction

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Command handshake from the SPI slave: 40-bit command word plus its valid level.
interface sump_cmd_decoder_if;

  logic [39:0] cmd;
  logic        execute;

  modport master (
    output cmd,
    output execute
  );

  modport slave (
    input cmd,
    input execute
  );

endinterface

// File: rtl/sump_trig_regs.sv
// Mask/value/config registers of one trigger stage, written by sub-op select.
module sump_trig_regs
  import sump_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  sub,
  input  logic [31:0] data,
  output logic [31:0] mask,
  output logic [31:0] value,
  output logic [31:0] cfg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      value <= '0;
      cfg   <= '0;
    end else if (we) begin
      case (sub)
        TRIG_SUB_MASK:  mask  <= data;
        TRIG_SUB_VALUE: value <= data;
        TRIG_SUB_CFG:   cfg   <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: edge-detects execute, decodes opcodes, owns the arm/capture FSM.
// Optional XON/XOFF transmit hold enabled by defining SUMP_CMD_XONXOFF_EN.
module sump_cmd_decoder
  import sump_cmd_pkg::*;
#(
  parameter int unsigned STAGES = 4,
  parameter int unsigned DIV_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sump_cmd_decoder_if.slave      bus,
  input  logic                   capture_done,
  output logic                   soft_reset,
  output logic                   arm,
  output logic                   armed,
  output logic [32*STAGES-1:0]   trig_mask,
  output logic [32*STAGES-1:0]   trig_value,
  output logic [32*STAGES-1:0]   trig_cfg,
  output logic [DIV_W-1:0]       divider,
  output logic [15:0]            read_count,
  output logic [15:0]            delay_count,
  output logic [31:0]            flags,
  output logic                   xoff,
  output logic                   cmd_reject
);

  logic        exec_q;
  logic        cmd_stb;
  logic [7:0]  opcode;
  logic [31:0] opdata;
  logic [1:0]  trig_stage;
  logic [1:0]  trig_sub;

  state_e state_q, state_d, state_cur;

  logic soft_reset_d, arm_d, reject_d;
  logic div_req, count_req, flags_req, trig_req;
  logic div_we, count_we, flags_we, trig_we;

  assign cmd_stb    = bus.execute & ~exec_q;
  assign opcode     = bus.cmd[7:0];
  assign opdata     = bus.cmd[39:8];
  assign trig_stage = bus.cmd[3:2];
  assign trig_sub   = bus.cmd[1:0];

  always_comb begin
    soft_reset_d = 1'b0;
    arm_d        = 1'b0;
    reject_d     = 1'b0;
    div_req      = 1'b0;
    count_req    = 1'b0;
    flags_req    = 1'b0;
    trig_req     = 1'b0;
    div_we       = 1'b0;
    count_we     = 1'b0;
    flags_we     = 1'b0;
    trig_we      = 1'b0;
    // capture_done lands before the command, so a same-cycle command sees IDLE.
    state_cur    = capture_done ? IDLE : state_q;
    state_d      = state_cur;

    if (cmd_stb) begin
      case (opcode)
        OP_RESET: begin
          soft_reset_d = 1'b1;
          state_d      = IDLE;
        end
        OP_ARM: begin
          if (state_cur == IDLE) begin
            arm_d   = 1'b1;
            state_d = ARMED;
          end else begin
            reject_d = 1'b1;
          end
        end
        OP_DIV:   div_req   = 1'b1;
        OP_COUNT: count_req = 1'b1;
        OP_FLAGS: flags_req = 1'b1;
        default: begin
          // Out-of-range stages and sub-op 11 are silently dropped, never rejected.
          trig_req = is_trig_op(opcode) && (trig_sub != TRIG_SUB_NONE) &&
                     ({30'd0, trig_stage} < STAGES);
        end
      endcase

      if (state_cur == ARMED) begin
        reject_d = reject_d | div_req | count_req | flags_req | trig_req;
      end else begin
        div_we   = div_req;
        count_we = count_req;
        flags_we = flags_req;
        trig_we  = trig_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q     <= 1'b0;
      state_q    <= IDLE;
      soft_reset <= 1'b0;
      arm        <= 1'b0;
      cmd_reject <= 1'b0;
    end else begin
      exec_q     <= bus.execute;
      state_q    <= state_d;
      soft_reset <= soft_reset_d;
      arm        <= arm_d;
      cmd_reject <= reject_d;
    end
  end

  assign armed = (state_q == ARMED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divider     <= '0;
      read_count  <= '0;
      delay_count <= '0;
      flags       <= '0;
    end else begin
      if (div_we) begin
        divider <= opdata[DIV_W-1:0];
      end
      if (count_we) begin
        read_count  <= opdata[15:0];
        delay_count <= opdata[31:16];
      end
      if (flags_we) begin
        flags <= opdata;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    sump_trig_regs u_trig_regs (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (trig_we && (trig_stage == 2'(g))),
      .sub   (trig_sub),
      .data  (opdata),
      .mask  (trig_mask[32*g +: 32]),
      .value (trig_value[32*g +: 32]),
      .cfg   (trig_cfg[32*g +: 32])
    );
  end

`ifdef SUMP_CMD_XONXOFF_EN
  // XON/XOFF bypass the capture gate; soft reset always releases the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xoff <= 1'b0;
    end else if (cmd_stb) begin
      if (opcode == OP_RESET || opcode == OP_XON) begin
        xoff <= 1'b0;
      end else if (opcode == OP_XOFF) begin
        xoff <= 1'b1;
      end
    end
  end
`else
  assign xoff = 1'b0;
`endif

endmodule
